mdbrot_plot_sink: RTL and testbench
===================================

Name: mdbrot_plot_sink

Overview:
- Receiving end of the pixel plot stream (x, y, colour, plot) that the escape-time Mandelbrot engine emits.
- Captures every plotted pixel into an on-chip 160x120 colour framebuffer and counts accepted plots.
- Flags frame completion and protocol errors.
- Exposes a synchronous readback port so frames can be checked and re-scanned without the VGA adapter.

Parameters:
- WIDTH, 160, horizontal pixels; x range 0..WIDTH-1.
- HEIGHT, 120, vertical pixels; y range 0..HEIGHT-1.
- CW, 3, colour width in bits.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- arm  in  1  one-cycle pulse; start capturing a frame.
- clear_req  in  1  one-cycle pulse; fill the framebuffer with clear_colour.
- clear_colour  in  CW  fill value, sampled on the cycle clear_req is accepted.
- plot_x  in  8  plot column.
- plot_y  in  7  plot row.
- plot_colour  in  CW  plot colour.
- plot  in  1  plot strobe; one pixel per high cycle, no backpressure.
- rd_en  in  1  readback request.
- rd_x  in  8  readback column.
- rd_y  in  7  readback row.
- rd_colour  out  CW  readback data.
- rd_valid  out  1  rd_colour valid.
- busy  out  1  high while in CLEAR.
- capturing  out  1  high while in CAPTURE.
- frame_done  out  1  high while in DONE.
- pixel_count  out  15  accepted plots in the current capture.
- oor_err  out  1  sticky; an out-of-range plot was seen in CAPTURE.
- drop_err  out  1  sticky; a plot arrived during CLEAR.

Behaviour:
- Reset values: state IDLE; all outputs 0. Reset mid-CLEAR aborts the fill; framebuffer contents are then unspecified.
- Framebuffer: WIDTH*HEIGHT = 19200 entries of CW bits. Address = y*WIDTH + x, computed as (y<<7)+(y<<5)+x, 15 bits unsigned.
- States: IDLE, CAPTURE, DONE, CLEAR.
- IDLE:
  - plot is ignored; no error is flagged.
  - arm -> CAPTURE. On entry, pixel_count=0 and oor_err=0.
- CAPTURE:
  - A plot with x<WIDTH and y<HEIGHT writes the colour at that address in the same clock edge.
  - pixel_count increments on each such write, duplicates included.
  - A plot with x>=WIDTH or y>=HEIGHT is not written, is not counted, and sets oor_err.
  - When the accepted plot brings pixel_count to 19200, the next state is DONE. frame_done rises one cycle after that plot.
  - arm while already in CAPTURE restarts the count at 0 and keeps framebuffer contents.
- DONE:
  - plot is ignored; pixel_count holds.
  - arm -> CAPTURE with the same entry actions as from IDLE.
- CLEAR:
  - Entered from IDLE, CAPTURE or DONE on clear_req. clear_req has priority over a simultaneous arm.
  - Writes clear_colour to addresses 0..19199, one per cycle. busy is high for exactly 19200 cycles, then state goes to IDLE.
  - pixel_count=0 on entry.
  - Any plot during CLEAR is dropped and sets drop_err.
  - clear_req and arm during CLEAR are ignored.
- Sticky flags: drop_err is cleared only by reset. oor_err is cleared by reset or by entry to CAPTURE.
- Readback:
  - Independent second port, usable in every state.
  - rd_en at cycle N gives rd_colour and rd_valid=1 at cycle N+1. rd_valid=0 when there was no request.
  - Out-of-range rd_x/rd_y returns 0 with rd_valid=1.
  - Read and write to the same address in the same cycle returns the old data.
- Counter width: pixel_count never exceeds 19200 and never wraps.

Test Plan:
- Reset, then arm. Plot raster order (x 0..159, y 0..119) with colour = (x+y)%8, one per cycle -> pixel_count=19200; frame_done=1 on the cycle after the last plot; oor_err=0. Readback (37,54) -> colour 3 one cycle after rd_en.
- In CAPTURE, plot (160,5) and (10,120) -> oor_err=1, pixel_count unchanged. Readback (0,5) is unchanged.
- clear_req with clear_colour=5 -> busy=1 for exactly 19200 cycles, then IDLE. Readback (0,0), (159,119) and (80,60) all return 5.
- Plot pulses during CLEAR -> drop_err=1. Framebuffer stays all clear_colour. drop_err survives a later arm.
- Same-cycle arm and clear_req from DONE -> CLEAR entered and arm discarded. After the clear, state is IDLE and capturing=0.
- Reset asserted at cycle 100 of a clear -> next cycle all outputs are 0 and state is IDLE. Plots are then ignored until arm.

Source files
------------

// File: rtl/mdbrot_plot_sink_if.sv
// mdbrot_plot_sink_if
// Groups the control, plot-stream, readback and status signals of the
// Mandelbrot plot sink. The master side (engine / host) drives
// arm/clear/plot/read requests. The slave side (the sink) drives readback
// data and status.
//   arm, clear_req, clear_colour           : capture / clear control
//   plot_x, plot_y, plot_colour, plot      : pixel plot stream, no backpressure
//   rd_en, rd_x, rd_y -> rd_colour, rd_valid : synchronous readback port
//   busy, capturing, frame_done, pixel_count, oor_err, drop_err : status
interface mdbrot_plot_sink_if #(
    parameter int CW = 3
);
    logic          arm;
    logic          clear_req;
    logic [CW-1:0] clear_colour;
    logic [7:0]    plot_x;
    logic [6:0]    plot_y;
    logic [CW-1:0] plot_colour;
    logic          plot;
    logic          rd_en;
    logic [7:0]    rd_x;
    logic [6:0]    rd_y;
    logic [CW-1:0] rd_colour;
    logic          rd_valid;
    logic          busy;
    logic          capturing;
    logic          frame_done;
    logic [14:0]   pixel_count;
    logic          oor_err;
    logic          drop_err;

    modport master (
        output arm, clear_req, clear_colour,
        output plot_x, plot_y, plot_colour, plot,
        output rd_en, rd_x, rd_y,
        input  rd_colour, rd_valid,
        input  busy, capturing, frame_done, pixel_count, oor_err, drop_err
    );

    modport slave (
        input  arm, clear_req, clear_colour,
        input  plot_x, plot_y, plot_colour, plot,
        input  rd_en, rd_x, rd_y,
        output rd_colour, rd_valid,
        output busy, capturing, frame_done, pixel_count, oor_err, drop_err
    );
endinterface

// File: rtl/mdbrot_plot_sink.sv
// mdbrot_plot_sink
// Receives the (x, y, colour, plot) pixel stream from the escape-time
// Mandelbrot engine and stores it in a 160x120 on-chip framebuffer. It counts
// accepted plots, flags frame completion, flags out-of-range and dropped
// plots, and can fill the framebuffer with a single colour. An independent
// one-cycle-latency readback port allows frame inspection in any state.
// Ports:
//   clock  : rising-edge system clock
//   resetn : synchronous active-low reset
//   pif    : mdbrot_plot_sink_if slave modport (control, plot stream,
//            readback and status)
module mdbrot_plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    mdbrot_plot_sink_if.slave     pif
);

    localparam int          NPIX_INT = WIDTH * HEIGHT;
    localparam logic [7:0]  X_LIM    = 8'(WIDTH);
    localparam logic [6:0]  Y_LIM    = 7'(HEIGHT);
    localparam logic [14:0] LAST_PIX = 15'(NPIX_INT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    // y*160 + x, written as shifts so no multiplier is needed
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    state_t        state_q, state_d;
    logic [14:0]   cnt_q, cnt_d;
    logic          oor_q, oor_d;
    logic          drop_q, drop_d;
    logic [14:0]   clr_addr_q, clr_addr_d;
    logic [CW-1:0] clr_col_q, clr_col_d;
    logic          busy_q, capturing_q, frame_done_q;
    logic          rd_valid_q;
    logic [CW-1:0] rd_colour_q;

    logic          wr_en_s;
    logic [14:0]   wr_addr_s;
    logic [CW-1:0] wr_data_s;
    logic          plot_in_range_s;
    logic          rd_in_range_s;
    logic [14:0]   plot_addr_s;
    logic [14:0]   rd_addr_s;

    logic [CW-1:0] fb_mem [0:NPIX_INT-1];

    assign plot_in_range_s = (pif.plot_x < X_LIM) && (pif.plot_y < Y_LIM);
    assign rd_in_range_s   = (pif.rd_x < X_LIM) && (pif.rd_y < Y_LIM);
    assign plot_addr_s     = pix_addr(pif.plot_x, pif.plot_y);
    assign rd_addr_s       = pix_addr(pif.rd_x, pif.rd_y);

    // Next-state, counter, sticky-flag and framebuffer write-port logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oor_d      = oor_q;
        drop_d     = drop_q;
        clr_addr_d = clr_addr_q;
        clr_col_d  = clr_col_q;
        wr_en_s    = 1'b0;
        wr_addr_s  = plot_addr_s;
        wr_data_s  = pif.plot_colour;

        case (state_q)
            ST_IDLE: begin
                if (pif.clear_req) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = 15'd0;
                    clr_addr_d = 15'd0;
                    clr_col_d  = pif.clear_colour;
                end else if (pif.arm) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = 15'd0;
                    oor_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (pif.plot) begin
                    if (plot_in_range_s) begin
                        wr_en_s = 1'b1;
                        cnt_d   = cnt_q + 15'd1;
                        // The plot that fills the last pixel completes the frame
                        if (cnt_q == LAST_PIX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        oor_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
                // Control requests override the plot's effect on state and count;
                // clear wins over a simultaneous arm.
                if (pif.clear_req) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = 15'd0;
                    clr_addr_d = 15'd0;
                    clr_col_d  = pif.clear_colour;
                end else if (pif.arm) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = 15'd0;
                    oor_d   = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q;
                end
            end
            ST_DONE: begin
                if (pif.clear_req) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = 15'd0;
                    clr_addr_d = 15'd0;
                    clr_col_d  = pif.clear_colour;
                end else if (pif.arm) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = 15'd0;
                    oor_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CLEAR: begin
                if (pif.plot) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                wr_en_s   = 1'b1;
                wr_addr_s = clr_addr_q;
                wr_data_s = clr_col_q;
                if (clr_addr_q == LAST_PIX) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 15'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, counters, flags and registered status outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 15'd0;
            oor_q        <= 1'b0;
            drop_q       <= 1'b0;
            clr_addr_q   <= 15'd0;
            clr_col_q    <= {CW{1'b0}};
            busy_q       <= 1'b0;
            capturing_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            oor_q        <= oor_d;
            drop_q       <= drop_d;
            clr_addr_q   <= clr_addr_d;
            clr_col_q    <= clr_col_d;
            busy_q       <= (state_d == ST_CLEAR);
            capturing_q  <= (state_d == ST_CAPTURE);
            frame_done_q <= (state_d == ST_DONE);
        end
    end

    // Framebuffer write port; no reset so it maps onto block RAM
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            fb_mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Readback port; non-blocking read returns the pre-write value on a collision
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_valid_q  <= 1'b0;
            rd_colour_q <= {CW{1'b0}};
        end else begin
            rd_valid_q <= pif.rd_en;
            if (pif.rd_en && rd_in_range_s) begin
                rd_colour_q <= fb_mem[rd_addr_s];
            end else begin
                rd_colour_q <= {CW{1'b0}};
            end
        end
    end

    assign pif.rd_colour   = rd_colour_q;
    assign pif.rd_valid    = rd_valid_q;
    assign pif.busy        = busy_q;
    assign pif.capturing   = capturing_q;
    assign pif.frame_done  = frame_done_q;
    assign pif.pixel_count = cnt_q;
    assign pif.oor_err     = oor_q;
    assign pif.drop_err    = drop_q;

endmodule

// File: tb/tb_mdbrot_plot_sink.sv
// tb_mdbrot_plot_sink
// Directed bench for mdbrot_plot_sink. Status outputs are compared directly
// after each step. Readback expectations are pushed into a scoreboard queue
// together with the cycle they are due. A separate monitor pops and compares
// them whenever rd_valid is seen.
module tb_mdbrot_plot_sink;

    typedef struct {
        int col;
        int due;
    } exp_t;

    logic clock = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    mdbrot_plot_sink_if #(.CW(3)) pif ();

    mdbrot_plot_sink #(.WIDTH(160), .HEIGHT(120), .CW(3)) dut (
        .clock  (clock),
        .resetn (resetn),
        .pif    (pif)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int x, input int y, input int exp);
        pif.rd_en = 1'b1;
        pif.rd_x  = 8'(x);
        pif.rd_y  = 7'(y);
        sb_q.push_back('{col: exp, due: cyc + 1});
        tick();
        pif.rd_en = 1'b0;
    endtask

    task automatic plot1(input int x, input int y, input int c);
        pif.plot        = 1'b1;
        pif.plot_x      = 8'(x);
        pif.plot_y      = 7'(y);
        pif.plot_colour = 3'(c);
        tick();
        pif.plot = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       int'(pif.busy),        0);
        chk({tag, "_capturing"},  int'(pif.capturing),   0);
        chk({tag, "_frame_done"}, int'(pif.frame_done),  0);
        chk({tag, "_count"},      int'(pif.pixel_count), 0);
        chk({tag, "_oor"},        int'(pif.oor_err),     0);
        chk({tag, "_drop"},       int'(pif.drop_err),    0);
        chk({tag, "_rd_valid"},   int'(pif.rd_valid),    0);
        chk({tag, "_rd_colour"},  int'(pif.rd_colour),   0);
    endtask

    // Readback monitor: compares data and latency against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
            e = sb_q.pop_front();
            chk("rd_missing_valid", 0, 1);
        end
        if (pif.rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_colour", int'(pif.rd_colour), e.col);
                chk("rd_latency", cyc, e.due);
            end
        end
    end

    initial begin
        int n;
        resetn           = 1'b0;
        pif.arm          = 1'b0;
        pif.clear_req    = 1'b0;
        pif.clear_colour = 3'd0;
        pif.plot_x       = 8'd0;
        pif.plot_y       = 7'd0;
        pif.plot_colour  = 3'd0;
        pif.plot         = 1'b0;
        pif.rd_en        = 1'b0;
        pif.rd_x         = 8'd0;
        pif.rd_y         = 7'd0;
        tick();
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;

        // Full raster frame, colour = (x+y)%8
        pif.arm = 1'b1;
        tick();
        pif.arm = 1'b0;
        chk("arm_capturing", int'(pif.capturing), 1);
        chk("arm_count", int'(pif.pixel_count), 0);
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                pif.plot        = 1'b1;
                pif.plot_x      = 8'(x);
                pif.plot_y      = 7'(y);
                pif.plot_colour = 3'((x + y) % 8);
                tick();
                if (y == 119 && x == 158) begin
                    chk("pre_last_count", int'(pif.pixel_count), 19199);
                    chk("pre_last_done", int'(pif.frame_done), 0);
                end
            end
        end
        pif.plot = 1'b0;
        chk("frame_done", int'(pif.frame_done), 1);
        chk("frame_capturing", int'(pif.capturing), 0);
        chk("frame_count", int'(pif.pixel_count), 19200);
        chk("frame_oor", int'(pif.oor_err), 0);
        plot1(0, 0, 7);
        chk("done_count_hold", int'(pif.pixel_count), 19200);
        rd(37, 54, 3);
        rd(200, 5, 0);
        rd(0, 0, 0);
        rd(159, 119, 6);

        // Arm + clear together from DONE; plots and requests during the clear
        pif.clear_colour = 3'd5;
        pif.clear_req    = 1'b1;
        pif.arm          = 1'b1;
        tick();
        pif.clear_req = 1'b0;
        pif.arm       = 1'b0;
        chk("clr_busy", int'(pif.busy), 1);
        chk("clr_capturing", int'(pif.capturing), 0);
        chk("clr_count", int'(pif.pixel_count), 0);
        n = 1;
        while (pif.busy && n < 20000) begin
            pif.plot        = (n == 50 || n == 51) ? 1'b1 : 1'b0;
            pif.plot_x      = (n == 50) ? 8'd1 : 8'd200;
            pif.plot_y      = (n == 50) ? 7'd1 : 7'd100;
            pif.plot_colour = 3'd2;
            pif.clear_req   = (n == 60) ? 1'b1 : 1'b0;
            pif.arm         = (n == 61) ? 1'b1 : 1'b0;
            tick();
            if (pif.busy) n++;
        end
        pif.plot      = 1'b0;
        pif.clear_req = 1'b0;
        pif.arm       = 1'b0;
        chk("clr_busy_cycles", n, 19200);
        chk("clr_end_busy", int'(pif.busy), 0);
        chk("clr_end_capturing", int'(pif.capturing), 0);
        chk("clr_end_done", int'(pif.frame_done), 0);
        chk("clr_drop_err", int'(pif.drop_err), 1);
        rd(0, 0, 5);
        rd(159, 119, 5);
        rd(80, 60, 5);
        rd(1, 1, 5);

        // Capture with out-of-range plots, a collision read and a re-arm
        pif.arm = 1'b1;
        tick();
        pif.arm = 1'b0;
        chk("rearm_capturing", int'(pif.capturing), 1);
        chk("rearm_drop_kept", int'(pif.drop_err), 1);
        plot1(160, 5, 1);
        plot1(10, 120, 1);
        chk("oor_err", int'(pif.oor_err), 1);
        chk("oor_count", int'(pif.pixel_count), 0);
        rd(0, 5, 5);
        rd(0, 6, 5);
        plot1(3, 3, 7);
        chk("valid_plot_count", int'(pif.pixel_count), 1);
        rd(3, 3, 7);
        pif.plot        = 1'b1;
        pif.plot_x      = 8'd4;
        pif.plot_y      = 7'd4;
        pif.plot_colour = 3'd1;
        pif.rd_en       = 1'b1;
        pif.rd_x        = 8'd4;
        pif.rd_y        = 7'd4;
        sb_q.push_back('{col: 5, due: cyc + 1});
        tick();
        pif.plot  = 1'b0;
        pif.rd_en = 1'b0;
        chk("collide_count", int'(pif.pixel_count), 2);
        rd(4, 4, 1);
        pif.arm = 1'b1;
        tick();
        pif.arm = 1'b0;
        chk("restart_count", int'(pif.pixel_count), 0);
        chk("restart_oor_clr", int'(pif.oor_err), 0);
        rd(3, 3, 7);

        // Reset in the 100th cycle of a clear
        pif.clear_colour = 3'd2;
        pif.clear_req    = 1'b1;
        tick();
        pif.clear_req = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        chk("mid_clr_busy", int'(pif.busy), 1);
        resetn = 1'b0;
        tick();
        chk_all_zero("clr_reset");
        resetn = 1'b1;
        plot1(5, 5, 3);
        plot1(6, 5, 3);
        plot1(200, 9, 3);
        chk("idle_plot_count", int'(pif.pixel_count), 0);
        chk("idle_plot_oor", int'(pif.oor_err), 0);
        chk("idle_plot_capturing", int'(pif.capturing), 0);
        chk("idle_plot_busy", int'(pif.busy), 0);
        pif.arm = 1'b1;
        tick();
        pif.arm = 1'b0;
        plot1(5, 5, 3);
        chk("post_reset_count", int'(pif.pixel_count), 1);
        rd(5, 5, 3);

        tick();
        tick();
        tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
